// File: rtl/pool_multi.sv
// Streaming spatial pooler for renkon feature maps.
// Consumes one map in raster order and emits pooled pixels in raster order.
// Window is 2x2 or 4x4 with stride equal to the window; reduction is max or average.
// Per-column partial results live in a column buffer, so no full line buffer is needed.
//
// Stream semantics: there is no backpressure. A pixel transfers on any cycle with
// in_valid high while a frame is running and start is low. out_valid marks a one-cycle
// pooled result; pixel_out holds its last value between results.
module pool_multi #(
   parameter int DWIDTH   = 16,
   parameter int LWIDTH   = 10,
   parameter int PLOG_MAX = 2,
   parameter int MAXW     = 256
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     start,
   input  logic                     mode,
   input  logic [1:0]               psize_log,
   input  logic [LWIDTH-1:0]        img_w,
   input  logic [LWIDTH-1:0]        img_h,
   input  logic                     in_valid,
   input  logic signed [DWIDTH-1:0] pixel_in,
   output logic                     out_valid,
   output logic signed [DWIDTH-1:0] pixel_out,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               state_dbg
);

   localparam int AW     = DWIDTH + 2 * PLOG_MAX;
   localparam int CDEPTH = MAXW / 2;
   localparam int CIW    = $clog2(CDEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t state;
   assign state_dbg = state;

   // Frame configuration, captured on start
   logic              cfg_mode;
   logic [1:0]        cfg_ps;
   logic [LWIDTH-1:0] cfg_w;
   logic [LWIDTH-1:0] cfg_h;

   logic [LWIDTH-1:0] x_cnt;
   logic [LWIDTH-1:0] y_cnt;
   logic signed [AW-1:0] hacc;
   logic              flush_cnt;

   // Stage 1: a completed window row waiting to merge into the column buffer
   logic              s1_valid;
   logic              s1_first_row;
   logic              s1_last_row;
   logic [CIW-1:0]    s1_wx;
   logic signed [AW-1:0] s1_hacc;

   logic signed [AW-1:0] colbuf [CDEPTH];

   function automatic logic signed [AW-1:0] combine(input logic m,
                                                    input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
      if (m) return a + b;
      else   return (a > b) ? a : b;
   endfunction

   logic [LWIDTH-1:0]    win_mask;
   logic [LWIDTH-1:0]    lim_x;
   logic [LWIDTH-1:0]    lim_y;
   logic [LWIDTH-1:0]    x_phase;
   logic [LWIDTH-1:0]    y_phase;
   logic                 accept;
   logic                 in_win;
   logic                 last_px;
   logic signed [AW-1:0] pix_ext;
   logic signed [AW-1:0] hacc_next;
   logic signed [AW-1:0] col_old;
   logic signed [AW-1:0] col_new;
   logic signed [AW-1:0] avg_val;
   logic signed [DWIDTH-1:0] res_px;

   // Window geometry, horizontal combine and column merge datapath
   always_comb begin
      win_mask  = ~({LWIDTH{1'b1}} << cfg_ps);
      lim_x     = cfg_w & ~win_mask;
      lim_y     = cfg_h & ~win_mask;
      x_phase   = x_cnt & win_mask;
      y_phase   = y_cnt & win_mask;
      accept    = in_valid && (state == S_RUN) && !start;
      in_win    = (x_cnt < lim_x) && (y_cnt < lim_y);
      last_px   = (x_cnt == cfg_w - LWIDTH'(1)) && (y_cnt == cfg_h - LWIDTH'(1));
      pix_ext   = {{(AW-DWIDTH){pixel_in[DWIDTH-1]}}, pixel_in};
      hacc_next = (x_phase == '0) ? pix_ext : combine(cfg_mode, hacc, pix_ext);
      col_old   = colbuf[s1_wx];
      col_new   = s1_first_row ? s1_hacc : combine(cfg_mode, col_old, s1_hacc);
      avg_val   = col_new >>> {cfg_ps, 1'b0};
      res_px    = cfg_mode ? avg_val[DWIDTH-1:0] : col_new[DWIDTH-1:0];
   end

   // Column buffer write; first-row writes overwrite, so it never needs clearing
   always_ff @(posedge clk) begin
      if (s1_valid && !start) colbuf[s1_wx] <= col_new;
   end

   // Control FSM, counters and the two pipeline stages with registered outputs
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state        <= S_IDLE;
         cfg_mode     <= 1'b0;
         cfg_ps       <= 2'd0;
         cfg_w        <= '0;
         cfg_h        <= '0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         hacc         <= '0;
         flush_cnt    <= 1'b0;
         s1_valid     <= 1'b0;
         s1_first_row <= 1'b0;
         s1_last_row  <= 1'b0;
         s1_wx        <= '0;
         s1_hacc      <= '0;
         out_valid    <= 1'b0;
         pixel_out    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // Abort whatever is in flight and begin a fresh frame
            cfg_mode  <= mode;
            cfg_ps    <= psize_log;
            cfg_w     <= img_w;
            cfg_h     <= img_h;
            x_cnt     <= '0;
            y_cnt     <= '0;
            hacc      <= '0;
            flush_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_RUN;
            busy      <= 1'b1;
         end else begin
            s1_valid <= accept && in_win && (x_phase == win_mask);
            if (accept) begin
               hacc         <= hacc_next;
               s1_hacc      <= hacc_next;
               s1_first_row <= (y_phase == '0);
               s1_last_row  <= (y_phase == win_mask);
               s1_wx        <= CIW'(x_cnt >> cfg_ps);
               if (x_cnt == cfg_w - LWIDTH'(1)) begin
                  x_cnt <= '0;
                  y_cnt <= last_px ? '0 : y_cnt + LWIDTH'(1);
               end else begin
                  x_cnt <= x_cnt + LWIDTH'(1);
               end
            end
            out_valid <= s1_valid && s1_last_row;
            if (s1_valid && s1_last_row) pixel_out <= res_px;
            case (state)
               S_IDLE: ;
               S_RUN: begin
                  if (accept && last_px) begin
                     state     <= S_FLUSH;
                     flush_cnt <= 1'b0;
                  end
               end
               S_FLUSH: begin
                  if (!flush_cnt) begin
                     flush_cnt <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pool_multi.sv
// Directed bench for pool_multi: hand-computed pooled values, latency and done timing.
module tb_pool_multi;

   localparam int DWIDTH = 16;
   localparam int LWIDTH = 10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic xrst = 1'b0;
   always #5 clk = ~clk;

   logic                     start = 1'b0;
   logic                     mode = 1'b0;
   logic [1:0]               psize_log = 2'd1;
   logic [LWIDTH-1:0]        img_w = '0;
   logic [LWIDTH-1:0]        img_h = '0;
   logic                     in_valid = 1'b0;
   logic signed [DWIDTH-1:0] pixel_in = '0;
   logic                     out_valid;
   logic signed [DWIDTH-1:0] pixel_out;
   logic                     busy;
   logic                     done;
   logic [1:0]               state_dbg;

   pool_multi #(.DWIDTH(DWIDTH), .LWIDTH(LWIDTH), .PLOG_MAX(2), .MAXW(256)) dut (
      .clk(clk), .xrst(xrst), .start(start), .mode(mode), .psize_log(psize_log),
      .img_w(img_w), .img_h(img_h), .in_valid(in_valid), .pixel_in(pixel_in),
      .out_valid(out_valid), .pixel_out(pixel_out), .busy(busy), .done(done),
      .state_dbg(state_dbg)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic signed [DWIDTH-1:0] exp_q[$];
   int lat_q[$];
   int exp_done_cyc = -1;
   int done_seen_cyc = -1;
   bit mon_busy_en = 1'b1;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) check("extra_out", 1, 0);
         else check("pix", pixel_out, exp_q.pop_front());
         if (lat_q.size() > 0) check("latency", cyc, lat_q.pop_front());
      end
      if (done) begin
         check("done_cyc", cyc, exp_done_cyc);
         done_seen_cyc = cyc;
      end
      if (mon_busy_en && prev_busy && !busy) check("busy_fall", cyc, done_seen_cyc + 1);
      prev_busy = busy;
   end

   // ---------------- driver ----------------
   int pix_mem[64];

   task automatic cyc_drive(input bit st, input bit v, input int pix);
      @(posedge clk);
      #1;
      start    = st;
      in_valid = v;
      pixel_in = DWIDTH'(pix);
   endtask

   task automatic feed_frame(input bit md, input logic [1:0] ps, input int w, input int h,
                             input bit bub, input bit start_px);
      int p;
      p = 1 << ps;
      mode = md; psize_log = ps; img_w = LWIDTH'(w); img_h = LWIDTH'(h);
      exp_done_cyc = -1;
      done_seen_cyc = -1;
      cyc_drive(1'b1, start_px, 99);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (bub) while ($urandom_range(0, 2) == 0) cyc_drive(1'b0, 1'b0, 0);
            cyc_drive(1'b0, 1'b1, pix_mem[y * w + x]);
            if (x == 0 && y == 0) check("busy_rise", busy, 1);
            if (x < (w / p) * p && y < (h / p) * p && x % p == p - 1 && y % p == p - 1)
               lat_q.push_back(cyc + 2);
            if (x == w - 1 && y == h - 1) exp_done_cyc = cyc + 2;
         end
      end
      cyc_drive(1'b0, 1'b0, 0);
      for (int i = 0; i < 10 && busy; i++) cyc_drive(1'b0, 1'b0, 0);
      check("frame_end", busy, 0);
      check("done_seen", done_seen_cyc, exp_done_cyc);
      cyc_drive(1'b0, 1'b0, 0);
      cyc_drive(1'b0, 1'b0, 0);
      check("missing_out", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 64; i++) pix_mem[i] = i;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_pixel_out", pixel_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state_dbg, 0);
      xrst = 1'b1;

      // 4x4 ramp, 2x2 max then average
      exp_q = '{5, 7, 13, 15};
      feed_frame(1'b0, 2'd1, 4, 4, 1'b0, 1'b0);
      exp_q = '{2, 4, 10, 12};
      feed_frame(1'b1, 2'd1, 4, 4, 1'b0, 1'b0);

      // 8x8 ramp, 4x4 max then average
      exp_q = '{27, 31, 59, 63};
      feed_frame(1'b0, 2'd2, 8, 8, 1'b0, 1'b0);
      exp_q = '{13, 17, 45, 49};
      feed_frame(1'b1, 2'd2, 8, 8, 1'b0, 1'b0);
      check("hold_pixel_out", pixel_out, 49);

      // 5x5 ramp: trailing column and row are dropped
      exp_q = '{6, 8, 16, 18};
      feed_frame(1'b0, 2'd1, 5, 5, 1'b0, 1'b0);

      // Negative averages: all -3, and {-1,0,0,0} floors to -1
      pix_mem[0] = -3; pix_mem[1] = -3; pix_mem[2] = -1; pix_mem[3] = 0;
      pix_mem[4] = -3; pix_mem[5] = -3; pix_mem[6] = 0;  pix_mem[7] = 0;
      exp_q = '{-3, -1};
      feed_frame(1'b1, 2'd1, 4, 2, 1'b0, 1'b0);
      exp_q = '{-3, -1};
      feed_frame(1'b1, 2'd1, 4, 2, 1'b1, 1'b0);
      exp_q = '{-3, 0};
      feed_frame(1'b0, 2'd1, 4, 2, 1'b1, 1'b0);
      for (int i = 0; i < 64; i++) pix_mem[i] = i;

      // Abort: 9 pixels of a 4x4 max frame, the 9th arriving with the new start
      mode = 1'b0; psize_log = 2'd1; img_w = 4; img_h = 4;
      exp_done_cyc = -1;
      exp_q = '{5};
      cyc_drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc_drive(1'b0, 1'b1, i);
         if (i == 5) lat_q.push_back(cyc + 2);
      end
      exp_q.push_back(13); exp_q.push_back(17); exp_q.push_back(45); exp_q.push_back(49);
      feed_frame(1'b1, 2'd2, 8, 8, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a frame
      mon_busy_en = 1'b0;
      mode = 1'b0; psize_log = 2'd2; img_w = 8; img_h = 8;
      cyc_drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 20; i++) cyc_drive(1'b0, 1'b1, i);
      check("mid_busy", busy, 1);
      #2 xrst = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_pixel_out", pixel_out, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_state", state_dbg, 0);
      cyc_drive(1'b0, 1'b0, 0);
      xrst = 1'b1;
      prev_busy = 1'b0;
      mon_busy_en = 1'b1;

      // Recovery frame after reset
      exp_q = '{5, 7, 13, 15};
      feed_frame(1'b0, 2'd1, 4, 4, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
